// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC accumulate stage.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int ACC_W_DEF = 40;
    localparam int LEN_DEF   = 16;
    localparam int PROD_W    = 32;

endpackage

// File: rtl/ripple_carry_adder10.sv
// Parameterised n-bit ripple-carry adder; cout_o is the carry out of the MSB.
module ripple_carry_adder10 #(
    parameter int n = 10
) (
    input  logic [n-1:0] a_i,
    input  logic [n-1:0] b_i,
    input  logic         cin_i,
    output logic [n-1:0] sum_o,
    output logic         cout_o
);

    logic [n:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < n; i++) begin : g_fa
        assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = carry[n];

endmodule

// File: rtl/mac_accumulator.sv
// Accumulates up to LEN unsigned products into an ACC_W-bit sum with sticky overflow.
// Define MAC_ACC_SAT_EN to saturate the sum on overflow instead of wrapping.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter  int ACC_W = ACC_W_DEF,
    parameter  int LEN   = LEN_DEF,
    localparam int CNT_W = $clog2(LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PROD_W-1:0]  in_product,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_result,
    output logic [CNT_W-1:0]   out_count,
    output logic               out_overflow,
    output logic [1:0]         dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both 1; valid/data are held by the source until that edge, ready is registered.

    state_e             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               ovf_q;
    logic               ovf_d;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [ACC_W-1:0]   out_result_q;
    logic [CNT_W-1:0]   out_count_q;
    logic               out_overflow_q;

    logic [ACC_W-1:0]   sum_w;
    logic               cout_w;
    logic               accept;
    logic               terminal;

    ripple_carry_adder10 #(
        .n (ACC_W)
    ) u_adder (
        .a_i    (acc_q),
        .b_i    (ACC_W'(in_product)),
        .cin_i  (1'b0),
        .sum_o  (sum_w),
        .cout_o (cout_w)
    );

    assign accept   = in_valid & in_ready_q;
    assign terminal = in_last | (cnt_q == CNT_W'(LEN - 1));

    always_comb begin
        ovf_d = ovf_q | cout_w;
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = sum_w;
`ifdef MAC_ACC_SAT_EN
        // Once clamped, the sum stays pinned at full scale for the rest of the vector.
        if (ovf_d) begin
            acc_d = '1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            cnt_q          <= '0;
            ovf_q          <= 1'b0;
            in_ready_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            out_result_q   <= '0;
            out_count_q    <= '0;
            out_overflow_q <= 1'b0;
        end else if (clear) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            cnt_q          <= '0;
            ovf_q          <= 1'b0;
            in_ready_q     <= 1'b1;
            out_valid_q    <= 1'b0;
            out_result_q   <= '0;
            out_count_q    <= '0;
            out_overflow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        ovf_q <= ovf_d;
                        if (terminal) begin
                            state_q        <= DONE;
                            in_ready_q     <= 1'b0;
                            out_valid_q    <= 1'b1;
                            out_result_q   <= acc_d;
                            out_count_q    <= cnt_d;
                            out_overflow_q <= ovf_d;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (out_valid_q && out_ready) begin
                        state_q     <= IDLE;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        ovf_q       <= 1'b0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_result   = out_result_q;
    assign out_count    = out_count_q;
    assign out_overflow = out_overflow_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator (default 40-bit instance plus a 32-bit instance).
module tb_mac_accumulator;

    localparam int LEN = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default instance (ACC_W=40)
    logic        rst_n, clear, in_valid, in_last, out_ready;
    logic        in_ready, out_valid, out_overflow;
    logic [31:0] in_product;
    logic [39:0] out_result;
    logic [4:0]  out_count;
    logic [1:0]  dbg_state;

    // narrow instance (ACC_W=32) for overflow behaviour
    logic        rst_n32, clear32, in_valid32, in_last32, out_ready32;
    logic        in_ready32, out_valid32, out_overflow32;
    logic [31:0] in_product32;
    logic [31:0] out_result32;
    logic [4:0]  out_count32;
    logic [1:0]  dbg_state32;

    mac_accumulator u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_product   (in_product),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_count    (out_count),
        .out_overflow (out_overflow),
        .dbg_state    (dbg_state)
    );

    mac_accumulator #(.ACC_W(32), .LEN(16)) u_dut32 (
        .clk          (clk),
        .rst_n        (rst_n32),
        .clear        (clear32),
        .in_valid     (in_valid32),
        .in_ready     (in_ready32),
        .in_product   (in_product32),
        .in_last      (in_last32),
        .out_valid    (out_valid32),
        .out_ready    (out_ready32),
        .out_result   (out_result32),
        .out_count    (out_count32),
        .out_overflow (out_overflow32),
        .dbg_state    (dbg_state32)
    );

    // ---------------- scoreboard / reference model ----------------
    int errors = 0;
    int checks = 0;

    // packed as {overflow, count[4:0], result[39:0]}
    logic [45:0] exp_q[$];
    logic [63:0] mdl_total;
    int          mdl_n;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural result of summing a vector whose true total is `total` in a w-bit accumulator.
    function automatic logic [63:0] ref_result(input logic [63:0] total, input int w);
        logic [63:0] lim;
        lim = 64'd1 << w;
        if (total < lim) return total;
`ifdef MAC_ACC_SAT_EN
        return lim - 64'd1;
`else
        return total % lim;
`endif
    endfunction

    function automatic logic ref_ovf(input logic [63:0] total, input int w);
        return total >= (64'd1 << w);
    endfunction

    task automatic model_reset();
        mdl_total = 64'd0;
        mdl_n     = 0;
    endtask

    task automatic model_add(input logic [31:0] p, input logic last);
        logic [63:0] r;
        mdl_total = mdl_total + 64'(p);
        mdl_n++;
        if (last || mdl_n == LEN) begin
            r = ref_result(mdl_total, 40);
            exp_q.push_back({ref_ovf(mdl_total, 40), 5'(mdl_n), r[39:0]});
            model_reset();
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] p, input logic last);
        int budget;
        budget     = 0;
        in_valid   = 1'b1;
        in_product = p;
        in_last    = last;
        while (!in_ready && budget < 20) begin
            step();
            budget++;
        end
        check("in_ready_wait", 64'(in_ready), 64'd1);
        step();
        model_add(p, last);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_result(input string tag);
        int          budget;
        logic [45:0] e;
        budget = 0;
        while (!out_valid && budget < 20) begin
            step();
            budget++;
        end
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_expq"}, 64'(exp_q.size()), 64'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_result"}, 64'(out_result), 64'(e[39:0]));
            check({tag, "_count"}, 64'(out_count), 64'(e[44:40]));
            check({tag, "_ovf"}, 64'(out_overflow), 64'(e[45]));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    endtask

    task automatic send32(input logic [31:0] p, input logic last);
        int budget;
        budget       = 0;
        in_valid32   = 1'b1;
        in_product32 = p;
        in_last32    = last;
        while (!in_ready32 && budget < 20) begin
            step();
            budget++;
        end
        check("in_ready32_wait", 64'(in_ready32), 64'd1);
        step();
        in_valid32 = 1'b0;
        in_last32  = 1'b0;
    endtask

    task automatic expect32(input string tag, input logic [63:0] total, input int n);
        int budget;
        budget = 0;
        while (!out_valid32 && budget < 20) begin
            step();
            budget++;
        end
        check({tag, "_valid"}, 64'(out_valid32), 64'd1);
        check({tag, "_result"}, 64'(out_result32), ref_result(total, 32));
        check({tag, "_count"}, 64'(out_count32), 64'(n));
        check({tag, "_ovf"}, 64'(out_overflow32), 64'(ref_ovf(total, 32)));
        out_ready32 = 1'b1;
        step();
        out_ready32 = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] tot32;
        logic [31:0] p;
        int          len;

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b0; in_product = '0;
        rst_n32 = 1'b0; clear32 = 1'b0; in_valid32 = 1'b0; in_last32 = 1'b0;
        out_ready32 = 1'b0; in_product32 = '0;
        model_reset();

        // reset state
        step();
        step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_count", 64'(out_count), 64'd0);
        check("rst_out_ovf", 64'(out_overflow), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        rst_n   = 1'b1;
        rst_n32 = 1'b1;
        step();

        // 16 terms of 1: terminal by count, latency one cycle, in_ready low in DONE
        for (int i = 0; i < LEN; i++) begin
            send(32'd1, 1'b0);
            if (i == LEN - 2) check("full_not_done_early", 64'(out_valid), 64'd0);
        end
        check("full_latency", 64'(out_valid), 64'd1);
        check("full_in_ready_done", 64'(in_ready), 64'd0);
        check("full_state_done", 64'(dbg_state), 64'd2);
        expect_result("full16");

        // short vector ended by in_last, then a single-term vector
        send(32'd3, 1'b0);
        send(32'd5, 1'b0);
        send(32'd7, 1'b1);
        expect_result("short3");
        send(32'd2, 1'b1);
        expect_result("single");

        // back-pressure: output held, input blocked for 5 cycles
        send($urandom, 1'b0);
        send($urandom, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid   = 1'b1;
            in_product = $urandom;
            step();
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_result", 64'(out_result), 64'(exp_q[0][39:0]));
            check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        expect_result("stall");
        send(32'd9, 1'b1);
        expect_result("after_stall");

        // clear after 4 terms, with a product presented in the clear cycle
        for (int i = 0; i < 4; i++) send($urandom, 1'b0);
        in_valid   = 1'b1;
        in_product = 32'd1000;
        clear      = 1'b1;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        model_reset();
        check("clear_state", 64'(dbg_state), 64'd0);
        check("clear_in_ready", 64'(in_ready), 64'd1);
        check("clear_out_valid", 64'(out_valid), 64'd0);
        for (int i = 0; i < LEN; i++) send(32'd2, 1'b0);
        expect_result("after_clear");

        // randomized vectors against the model
        for (int v = 0; v < 8; v++) begin
            len = $urandom_range(1, LEN);
            for (int i = 0; i < len; i++) begin
                send($urandom, (i == len - 1) && ((len < LEN) || ($urandom_range(0, 1) == 1)));
            end
            expect_result("random");
        end

        // reset while in DONE drops the result
        send(32'd11, 1'b0);
        send(32'd12, 1'b1);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        step();
        void'(exp_q.pop_front());
        check("done_rst_valid", 64'(out_valid), 64'd0);
        check("done_rst_result", 64'(out_result), 64'd0);
        check("done_rst_count", 64'(out_count), 64'd0);
        check("done_rst_ovf", 64'(out_overflow), 64'd0);
        check("done_rst_state", 64'(dbg_state), 64'd0);
        rst_n = 1'b1;
        step();
        step();
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        send(32'd4, 1'b1);
        expect_result("post_rst");

        // 32-bit accumulator: carry-out handling
        send32(32'hFFFF_FFFF, 1'b0);
        send32(32'hFFFF_FFFF, 1'b1);
        expect32("ovf32_two", 64'h1_FFFF_FFFE, 2);
        send32(32'd5, 1'b1);
        expect32("ovf32_clean", 64'd5, 1);
        tot32 = 64'd0;
        for (int i = 0; i < LEN; i++) begin
            p     = 32'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom);
            tot32 = tot32 + 64'(p);
            send32(p, 1'b0);
        end
        expect32("ovf32_random", tot32, LEN);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Sequential accumulate stage directly downstream of the 16x16 unsigned shift-add multiplier in the MAC datapath.
- Accepts a stream of 32-bit unsigned products over a valid/ready handshake and sums LEN terms (or fewer, if in_last is asserted) into an ACC_W-bit accumulator.
- Presents the dot-product result on a second valid/ready handshake, with a sticky overflow indication.

Parameters:
- ACC_W, 40, accumulator and result width in bits; must be >= 32.
- LEN, 16, number of products per accumulation; must be >= 1.
- CNT_W, $clog2(LEN+1), term-counter width (derived; not overridden).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- clear  input  1  synchronous abort: discard partial sum and return to IDLE.
- in_valid  input  1  product on in_product is valid.
- in_ready  output  1  block can accept a product this cycle.
- in_product  input  32  unsigned product from the multiplier.
- in_last  input  1  qualifies in_valid: this is the final term of the vector, even if fewer than LEN terms.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- out_result  output  ACC_W  accumulated sum.
- out_count  output  CNT_W  number of terms summed into out_result.
- out_overflow  output  1  sum exceeded ACC_W bits during this accumulation.

Behaviour:
- States:
  - IDLE: acc=0, cnt=0.
  - ACCUM: at least one term accepted.
  - DONE: result held for output.
- Reset (rst_n=0 at clk edge):
  - state=IDLE; acc, cnt, overflow flag = 0.
  - out_valid=0, out_result=0, out_count=0, out_overflow=0, in_ready=0 during the reset cycle.
  - Reset mid-accumulation or mid-DONE drops all data.
- Priority: rst_n > clear > handshakes.
  - clear=1 behaves like reset for state and registers, except in_ready follows state normally on the next cycle.
  - A product presented in the same cycle as clear is NOT accepted.
- in_ready = 1 in IDLE and ACCUM; 0 in DONE. Input accept = in_valid & in_ready.
- On accept in IDLE or ACCUM:
  - acc <= acc + zero-extended in_product.
  - cnt <= cnt + 1.
  - Overflow flag is set if the ACC_W-bit add carries out; it is sticky until the result is consumed.
  - IDLE moves to ACCUM.
- Terminal accept: the accept where cnt == LEN-1, or where in_last=1.
  - Next state is DONE.
  - out_result/out_count/out_overflow load the updated values, and out_valid=1 on the following cycle (latency 1 cycle from the last accept).
- DONE:
  - Outputs are held stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: state=IDLE, acc/cnt/flag cleared, out_valid=0 next cycle.
  - The next product can be accepted the cycle after the output handshake (no overlap; one bubble per vector).
- in_valid without accept: no change.
- out_ready outside DONE: ignored.
- Counter never exceeds LEN; in_last on the very first term yields out_count=1.

Optional Feature:
- Macro MAC_ACC_SAT_EN.
  - Defined: on any carry-out, acc clamps to 2^ACC_W-1 and stays there for the rest of the vector; out_overflow is still set.
  - Undefined: acc wraps modulo 2^ACC_W; out_overflow flags the wrap.

Decomposition:
- Shared package mac_pkg holds:
  - state encoding typedef (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2);
  - default ACC_W/LEN constants;
  - product width constant 32.
- Natural sub-module: the accumulate adder reuses the team's ripple_carry_adder10 with n=ACC_W; its cout drives the overflow logic.
- FSM, counter and output registers live in mac_accumulator.

Test Plan:
- Reset, then 16 accepts of in_product=1, out_ready=1 -> out_valid one cycle after the 16th accept; out_result=16, out_count=16, out_overflow=0; in_ready=0 while in DONE.
- Products 3, 5, 7 with in_last on 7 -> out_result=15, out_count=3; the next vector starts clean (a single product 2 with in_last gives 2).
- ACC_W=32, two products 0xFFFFFFFF -> out_overflow=1.
  - Macro off: out_result=0xFFFFFFFE.
  - MAC_ACC_SAT_EN on: out_result=0xFFFFFFFF.
- out_ready held 0 for 5 cycles in DONE, then in_valid pulsed -> outputs stable, in_ready=0, no product accepted; result consumed on the out_ready=1 cycle.
- clear asserted after 4 of 16 terms (in_valid=1 in the same cycle) -> that term is dropped; the next 16 accepts of value 2 give out_result=32.
- rst_n=0 for one cycle while in DONE -> out_valid=0 and all outputs 0 next cycle; IDLE entered.
